reg_file: RTL
=============

# reg_file

Architectural register file with per-register rename tags for the out-of-order core. Sits between the ROB commit port and the dispatcher. It takes in-order commits (value, rd, ROB alias) from the ROB, and records each new rd rename issued by the dispatcher. It answers the dispatcher's rs1/rs2 operand queries combinationally, returning either a committed value or the ROB alias that will produce it.

## Interface
Parameters:
- REG_NUM, 32: architectural registers; x0 hard-wired to zero.
- ROB_ID_WIDTH, 4: alias width. Alias 0 means "not renamed"; valid ROB ids are 1..2^ROB_ID_WIDTH-1.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (all state cleared while low).
- rdy  in  1  global run enable; low = pause.
- rollback_signal  in  1  ROB misprediction flush.
- rename_ena_from_dsp  in  1  dispatcher issues an instruction that writes rd.
- rename_rd_from_dsp  in  5  rd of that instruction.
- renameid_from_dsp  in  ROB_ID_WIDTH  ROB slot allocated to it.
- rs1_from_dsp, rs2_from_dsp  in  5 each  source register indices.
- Vi_2dsp, Vj_2dsp  out  32 each  rs1/rs2 value, meaningful when Q=0.
- Qi_2dsp, Qj_2dsp  out  ROB_ID_WIDTH each  rs1/rs2 producing alias; 0 = value ready.
- res_rdy_from_rob  in  1  commit write valid.
- regidx_from_rob  in  5  commit rd.
- res_from_rob  in  32  commit value.
- alias_from_rob  in  ROB_ID_WIDTH  ROB id of the committing instruction.

## Operation
- State per register: val[31:0] and alias[ROB_ID_WIDTH-1:0]. A register is busy iff alias != 0.
- Reset (rst low, asynchronous): all val=0, all alias=0. Outputs are then combinational: Q*=0, V*=0.
- Commit (res_rdy_from_rob, regidx != 0):
  - val[regidx] <= res_from_rob, unconditionally.
  - alias[regidx] <= 0 only if alias[regidx]==alias_from_rob. If they differ, a younger rename is pending and alias is kept.
- Rename (rename_ena_from_dsp, rd != 0, rollback_signal low): alias[rd] <= renameid_from_dsp.
- Commit and rename to the same rd in one cycle: value is written and alias becomes renameid (rename wins).
- Rollback (rollback_signal high): all alias <= 0 and any rename that cycle is dropped. A commit in the same cycle still writes val, because the ROB can present the committing branch's rd write alongside the flush.
- rdy low:
  - Commit and rename are ignored.
  - Rollback, together with its accompanying commit write, is still applied, because the ROB flushes regardless of rdy.
- Writes and renames targeting x0 are ignored.
- Query (combinational): Q = alias[rs], V = val[rs]. rs=0 always returns Q=0, V=0.

## Timing
- State updates on the rising clk edge; queries are zero-latency combinational.
- A rename made at edge N is visible to queries from cycle N+1.
- A commit at edge N clears busy from cycle N+1. Without bypass, a query in cycle N still sees the old alias and must resolve the operand through the ROB ready/value lookup.
- No handshake or backpressure; every valid input is accepted in its cycle.

## Configuration
- REGFILE_BYPASS_EN defined: commit-to-query bypass. In the commit cycle, if res_rdy_from_rob && regidx==rs && rs!=0 && alias_from_rob==alias[rs], the query returns Q=0 and V=res_from_rob. Same-cycle renames are not bypassed.
- Undefined: queries reflect registered state only.

## Structure
- Shared const package holds:
  - REG_RANGE, DATA_IDX_RANGE, ROB_ID_RANGE, ZERO, TRUE/FALSE.
  - A NO_ALIAS=0 constant, added there.
- Single module; no sub-module. The two query ports are one repeated combinational expression, generated or written out twice.

## Test plan
- Reset, then query rs1=5, rs2=0 -> Qi=0, Vi=0, Qj=0, Vj=0.
- Rename x5->id 3; next cycle query rs1=5 -> Qi=3. Commit (x5, 0x1234, id 3) -> next cycle Qi=0, Vi=0x1234.
- Rename x5->3, then x5->7, then commit (x5, 0xAA, id 3) -> Vi=0xAA but Qi remains 7.
- Same cycle: commit (x6, 0x55, id 2) and rename x6->4 -> next cycle Qi=4, Vi=0x55.
- Rename x1->2 and x2->5; assert rollback with commit (x3, 0x99, id 1) and rename x4->6 in the same cycle. Next cycle: Q=0 for x1, x2, x4; x3 val=0x99. Repeat with rdy low: same result.
- Commit (x0, 0xFF, id 1) and rename x0->2 -> query rs1=0 gives Qi=0, Vi=0. With REGFILE_BYPASS_EN: x7 alias 4, commit (x7, 0x42, id 4) -> same-cycle query Qi=0, Vi=0x42.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the architectural register file: index/data/alias
// widths, zero and boolean literals, and the "not renamed" alias value.
package reg_file_pkg;

    // Width of an architectural register index (x0..x31)
    localparam int REG_RANGE      = 5;
    // Width of a register data word
    localparam int DATA_IDX_RANGE = 32;
    // Default width of a ROB alias
    localparam int ROB_ID_RANGE   = 4;

    localparam logic [DATA_IDX_RANGE-1:0] ZERO = '0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Alias value meaning "register holds its committed value"
    localparam int NO_ALIAS = 0;

endpackage

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Takes in-order commits from the ROB, records dispatcher renames and answers
// two combinational operand queries (value or producing ROB alias).
// Optional macro REGFILE_BYPASS_EN: a commit that retires the alias a query
// is waiting on is forwarded to that query in the same cycle.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_NUM      = 32,
    parameter int ROB_ID_WIDTH = ROB_ID_RANGE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rollback_signal,
    input  logic                      rename_ena_from_dsp,
    input  logic [REG_RANGE-1:0]      rename_rd_from_dsp,
    input  logic [ROB_ID_WIDTH-1:0]   renameid_from_dsp,
    input  logic [REG_RANGE-1:0]      rs1_from_dsp,
    input  logic [REG_RANGE-1:0]      rs2_from_dsp,
    output logic [DATA_IDX_RANGE-1:0] Vi_2dsp,
    output logic [DATA_IDX_RANGE-1:0] Vj_2dsp,
    output logic [ROB_ID_WIDTH-1:0]   Qi_2dsp,
    output logic [ROB_ID_WIDTH-1:0]   Qj_2dsp,
    input  logic                      res_rdy_from_rob,
    input  logic [REG_RANGE-1:0]      regidx_from_rob,
    input  logic [DATA_IDX_RANGE-1:0] res_from_rob,
    input  logic [ROB_ID_WIDTH-1:0]   alias_from_rob
);

    localparam logic [ROB_ID_WIDTH-1:0] ALIAS_NONE = ROB_ID_WIDTH'(NO_ALIAS);

    logic [DATA_IDX_RANGE-1:0] val_reg   [REG_NUM];
    logic [ROB_ID_WIDTH-1:0]   alias_reg [REG_NUM];

    logic commit_en;
    logic rename_en;
    logic commit_clears_alias;

    // A flush commits its accompanying write even while paused; x0 is never written
    assign commit_en = res_rdy_from_rob && (regidx_from_rob != '0)
                       && (rdy || rollback_signal);
    // Renames need the core running and are dropped by a flush
    assign rename_en = rename_ena_from_dsp && (rename_rd_from_dsp != '0)
                       && rdy && !rollback_signal;
    // Busy clears only if no younger rename has replaced the committing alias
    assign commit_clears_alias = commit_en
                                 && (alias_reg[regidx_from_rob] == alias_from_rob);

    // Register state: values follow commits, aliases follow renames/commits/flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_reg[i]   <= ZERO;
                alias_reg[i] <= ALIAS_NONE;
            end
        end else begin
            if (commit_en) begin
                val_reg[regidx_from_rob] <= res_from_rob;
            end
            if (rollback_signal) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    alias_reg[i] <= ALIAS_NONE;
                end
            end else if (rdy) begin
                if (commit_clears_alias) begin
                    alias_reg[regidx_from_rob] <= ALIAS_NONE;
                end
                // Placed last so a same-cycle rename of the committing rd wins
                if (rename_en) begin
                    alias_reg[rename_rd_from_dsp] <= renameid_from_dsp;
                end
            end
        end
    end

    logic [REG_RANGE-1:0]      rs_sel [2];
    logic [DATA_IDX_RANGE-1:0] v_out  [2];
    logic [ROB_ID_WIDTH-1:0]   q_out  [2];

    assign rs_sel[0] = rs1_from_dsp;
    assign rs_sel[1] = rs2_from_dsp;

    // Identical combinational lookup for both source operand ports
    for (genvar gi = 0; gi < 2; gi++) begin : g_query
        logic is_x0;
        logic bypass_hit;

        assign is_x0 = (rs_sel[gi] == '0);
`ifdef REGFILE_BYPASS_EN
        assign bypass_hit = res_rdy_from_rob && (regidx_from_rob == rs_sel[gi])
                            && (alias_from_rob == alias_reg[rs_sel[gi]]);
`else
        assign bypass_hit = FALSE;
`endif
        assign q_out[gi] = (is_x0 || bypass_hit) ? ALIAS_NONE : alias_reg[rs_sel[gi]];
        assign v_out[gi] = is_x0      ? ZERO :
                           bypass_hit ? res_from_rob : val_reg[rs_sel[gi]];
    end

    assign Vi_2dsp = v_out[0];
    assign Qi_2dsp = q_out[0];
    assign Vj_2dsp = v_out[1];
    assign Qj_2dsp = q_out[1];

endmodule
